// File: rtl/dog_action_sched.sv
// Frame-synchronous scheduler for the dog sprite layers: run/eat/lh buttons to
// sprite position and animation frame selects. Optional vertical bounce: DYN_BOUNCE_EN.
module dog_action_sched #(
  parameter int unsigned FRAME_DIV = 6,
  parameter int unsigned STEP_X    = 4,
  parameter int unsigned X_MIN     = 0,
  parameter int unsigned X_MAX     = 576,
  parameter int unsigned X_INIT    = 288,
  parameter int unsigned Y_GROUND  = 300,
  parameter int unsigned N_RUN     = 6,
  parameter int unsigned EAT_STEPS = 8,
  parameter bit          VS_POL    = 1'b0
) (
  input  logic       pixel_clk,
  input  logic       reset,
  input  logic       vSync,
  input  logic       run,
  input  logic       eat,
  input  logic       lh,
  output logic [2:0] ActionSel,
  output logic [9:0] DogPos_x,
  output logic [8:0] DogPos_y,
  output logic       ActionS,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, RUN, EAT} state_t;

  localparam logic [5:0]  FD_LAST   = 6'(FRAME_DIV - 1);
  localparam logic [2:0]  SEL_LAST  = 3'(N_RUN - 1);
  localparam logic [7:0]  EAT_LAST  = 8'(EAT_STEPS - 1);
  localparam logic [10:0] XMIN11    = 11'(X_MIN);
  localparam logic [10:0] XMAX11    = 11'(X_MAX);
  localparam logic [10:0] STEPX11   = 11'(STEP_X);

  state_t     state, state_nx;
  logic [1:0] run_ff, eat_ff, lh_ff;
  logic       eat_d, vs_d, frame_tick;
  logic [5:0] frame_cnt;
  logic [7:0] step_cnt, step_cnt_nx;
  logic       eat_pend, eat_pend_nx;
  logic [2:0] sel_nx;
  logic [9:0] x_nx;
  logic       as_nx, busy_nx;

  logic       run_sync, lh_sync, eat_req, step_tick;
  logic [10:0] x11, x_left, x_right, x_mv;
  logic       blocked;
  logic [2:0] sel_adv;

  assign run_sync  = run_ff[1];
  assign lh_sync   = lh_ff[1];
  assign eat_req   = eat_ff[1] & ~eat_d;
  assign step_tick = frame_tick && (frame_cnt == FD_LAST);

  always_ff @(posedge pixel_clk or negedge reset) begin
    if (!reset) begin
      run_ff     <= '0;
      eat_ff     <= '0;
      lh_ff      <= '0;
      eat_d      <= 1'b0;
      vs_d       <= 1'b0;
      frame_tick <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      run_ff     <= {run_ff[0], run};
      eat_ff     <= {eat_ff[0], eat};
      lh_ff      <= {lh_ff[0], lh};
      eat_d      <= eat_ff[1];
      vs_d       <= vSync;
      frame_tick <= (vSync == VS_POL) && (vs_d != VS_POL);
      if (frame_tick)
        frame_cnt <= (frame_cnt == FD_LAST) ? '0 : frame_cnt + 6'd1;
    end
  end

  // Candidate position for a run step, computed in 11 bits so neither edge wraps
  always_comb begin
    x11     = {1'b0, DogPos_x};
    x_right = x11 + STEPX11;
    if (x_right > XMAX11) x_right = XMAX11;
    x_left  = (x11 >= XMIN11 + STEPX11) ? x11 - STEPX11 : XMIN11;
    x_mv    = lh_sync ? x_left : x_right;
    blocked = lh_sync ? (x11 <= XMIN11) : (x11 >= XMAX11);
    sel_adv = (ActionSel == SEL_LAST) ? '0 : ActionSel + 3'd1;
  end

  always_comb begin
    state_nx    = state;
    sel_nx      = ActionSel;
    x_nx        = DogPos_x;
    as_nx       = ActionS;
    busy_nx     = busy;
    step_cnt_nx = step_cnt;
    eat_pend_nx = eat_pend;
    case (state)
      EAT: begin
        if (step_tick) begin
          if (step_cnt == EAT_LAST) begin
            state_nx = run_sync ? RUN : IDLE;
            as_nx    = 1'b0;
            busy_nx  = 1'b0;
          end else begin
            step_cnt_nx = step_cnt + 8'd1;
            as_nx       = ~ActionS;
          end
        end
      end
      default: begin
        if (eat_req) eat_pend_nx = 1'b1;
        // IDLE and RUN share one step rule: a step with run held is a run step
        if (step_tick) begin
          if (eat_pend || eat_req) begin
            state_nx    = EAT;
            eat_pend_nx = 1'b0;
            step_cnt_nx = '0;
            busy_nx     = 1'b1;
            sel_nx      = '0;
            as_nx       = 1'b0;
          end else if (run_sync) begin
            state_nx = RUN;
            if (blocked) begin
              sel_nx = '0;
            end else begin
              sel_nx = sel_adv;
              x_nx   = x_mv[9:0];
            end
          end else begin
            state_nx = IDLE;
            sel_nx   = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge pixel_clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ActionSel <= '0;
      DogPos_x  <= 10'(X_INIT);
      ActionS   <= 1'b0;
      busy      <= 1'b0;
      step_cnt  <= '0;
      eat_pend  <= 1'b0;
    end else begin
      state     <= state_nx;
      ActionSel <= sel_nx;
      DogPos_x  <= x_nx;
      ActionS   <= as_nx;
      busy      <= busy_nx;
      step_cnt  <= step_cnt_nx;
      eat_pend  <= eat_pend_nx;
    end
  end

`ifdef DYN_BOUNCE_EN
  // ActionSel is zero whenever not running or blocked, so its LSB alone selects the hop
  assign DogPos_y = ActionSel[0] ? 9'(Y_GROUND - 2) : 9'(Y_GROUND);
`else
  assign DogPos_y = 9'(Y_GROUND);
`endif

endmodule
